// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Pixel/line counters with zero-skew registered sync, active
//                and line/frame-start decodes for a VGA-style raster.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int         c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_act    = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_act    = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_active;
    logic       r_line_start;
    logic       r_frame_start;

    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic       w_hsync_next;
    logic       w_vsync_next;
    logic       w_active_next;
    logic       w_line_start_next;
    logic       w_frame_start_next;

    // The >= wrap test keeps the counters in range even from a corrupted state.
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (ce) begin
            if (r_x >= c_h_last) begin
                w_x_next = '0;
                w_y_next = (r_y >= c_v_last) ? '0 : r_y + 10'd1;
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end
    end

    // Decode the position about to be loaded so flags line up with x/y.
    always_comb begin
        w_hsync_next       = !((w_x_next >= c_hs_start) && (w_x_next < c_hs_end));
        w_vsync_next       = !((w_y_next >= c_vs_start) && (w_y_next < c_vs_end));
        w_active_next      = (w_x_next < c_h_act) && (w_y_next < c_v_act);
        w_line_start_next  = (w_x_next == 10'd0);
        w_frame_start_next = (w_x_next == 10'd0) && (w_y_next == 10'd0);
    end

    // Reset parks on the last pixel of the frame; its decode is all-idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x           <= c_h_last;
            r_y           <= c_v_last;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (ce) begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_active      <= w_active_next;
            r_line_start  <= w_line_start_next;
            r_frame_start <= w_frame_start_next;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench: default-size and reduced-size instances
//                compared every edge against a reference raster model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int BHA = 640, BHF = 16, BHS = 96, BHB = 48;
    localparam int BVA = 480, BVF = 10, BVS = 2,  BVB = 33;
    localparam int SHA = 16,  SHF = 4,  SHS = 6,  SHB = 6;
    localparam int SVA = 12,  SVF = 2,  SVS = 2,  SVB = 4;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       act;
        logic       ls;
        logic       fs;
    } obs_t;

    typedef struct {
        logic ce;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    logic       b_hs, b_vs, b_act, b_ls, b_fs;
    logic [9:0] b_x, b_y;
    logic       s_hs, s_vs, s_act, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    obs_t       b_obs, s_obs;

    assign b_obs = {b_x, b_y, b_hs, b_vs, b_act, b_ls, b_fs};
    assign s_obs = {s_x, s_y, s_hs, s_vs, s_act, s_ls, s_fs};

    always #5 clk = ~clk;

    vga_timing_gen u_big (
        .clk(clk), .rst(rst), .ce(ce),
        .hsync(b_hs), .vsync(b_vs), .active(b_act),
        .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) u_small (
        .clk(clk), .rst(rst), .ce(ce),
        .hsync(s_hs), .vsync(s_vs), .active(s_act),
        .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   mbx, mby, msx, msy;
    obs_t q_big[$];
    obs_t q_small[$];
    vec_t vecs[6];

    function automatic obs_t mk(int xx, int yy, bit hs, bit vs, bit a, bit ls, bit fs);
        obs_t o;
        o.x = 10'(xx); o.y = 10'(yy);
        o.hs = hs; o.vs = vs; o.act = a; o.ls = ls; o.fs = fs;
        return o;
    endfunction

    function automatic obs_t decode(int xx, int yy, int ha, int hf, int hsw,
                                    int va, int vf, int vsw);
        return mk(xx, yy,
                  !(xx >= ha + hf && xx < ha + hf + hsw),
                  !(yy >= va + vf && yy < va + vf + vsw),
                  (xx < ha) && (yy < va),
                  xx == 0,
                  xx == 0 && yy == 0);
    endfunction

    function automatic obs_t big_exp();
        return decode(mbx, mby, BHA, BHF, BHS, BVA, BVF, BVS);
    endfunction

    function automatic obs_t small_exp();
        return decode(msx, msy, SHA, SHF, SHS, SVA, SVF, SVS);
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
                     name, $time, act.x, act.y, act.hs, act.vs, act.act, act.ls, act.fs,
                     exp.x, exp.y, exp.hs, exp.vs, exp.act, exp.ls, exp.fs);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic step_models();
        if (mbx == BHT - 1) begin
            mbx = 0;
            mby = (mby == BVT - 1) ? 0 : mby + 1;
        end else mbx++;
        if (msx == SHT - 1) begin
            msx = 0;
            msy = (msy == SVT - 1) ? 0 : msy + 1;
        end else msx++;
    endtask

    // Called just after an edge; drives ce, queues expectations, checks after next edge.
    task automatic tick(input logic c, input logic use_tab, input obs_t tab);
        ce = c;
        if (c) step_models();
        q_big.push_back(use_tab ? tab : big_exp());
        q_small.push_back(small_exp());
        @(posedge clk);
        #1;
        check("big", b_obs, q_big.pop_front());
        check("small", s_obs, q_small.pop_front());
    endtask

    // Asserts rst between edges and checks the outputs before any edge arrives.
    task automatic do_reset(input string name);
        #3;
        rst = 1'b1;
        #1;
        mbx = BHT - 1; mby = BVT - 1;
        msx = SHT - 1; msy = SVT - 1;
        check({name, "_big"}, b_obs, mk(799, 524, 1, 1, 0, 0, 0));
        check({name, "_small"}, s_obs, mk(SHT - 1, SVT - 1, 1, 1, 0, 0, 0));
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_act, cnt_hs, first_hs, cnt_ls, cnt_vs, cnt_bad, cnt_fs, f0, f1;
        logic prev_fs;

        vecs[0] = '{1'b1, mk(0, 0, 1, 1, 1, 1, 1)};
        vecs[1] = '{1'b0, mk(0, 0, 1, 1, 1, 1, 1)};
        vecs[2] = '{1'b1, mk(1, 0, 1, 1, 1, 0, 0)};
        vecs[3] = '{1'b0, mk(1, 0, 1, 1, 1, 0, 0)};
        vecs[4] = '{1'b1, mk(2, 0, 1, 1, 1, 0, 0)};
        vecs[5] = '{1'b1, mk(3, 0, 1, 1, 1, 0, 0)};

        rst = 1'b1;
        ce  = 1'b1;
        mbx = BHT - 1; mby = BVT - 1;
        msx = SHT - 1; msy = SVT - 1;
        #2;
        check("por_big", b_obs, mk(799, 524, 1, 1, 0, 0, 0));
        @(posedge clk);
        #1;
        check("rst_held_big", b_obs, mk(799, 524, 1, 1, 0, 0, 0));
        check("rst_held_small", s_obs, small_exp());
        rst = 1'b0;

        // First edges after release, including ce=0 holds
        foreach (vecs[i]) tick(vecs[i].ce, 1'b1, vecs[i].exp);

        // One full default line from (0,0)
        do_reset("rst_line");
        cnt_act = 0; cnt_hs = 0; first_hs = -1; cnt_ls = 0;
        for (int i = 0; i < BHT; i++) begin
            tick(1'b1, 1'b0, '0);
            if (b_act) cnt_act++;
            if (!b_hs) begin
                cnt_hs++;
                if (first_hs < 0) first_hs = int'(b_x);
            end
            if (b_ls) cnt_ls++;
        end
        check_int("line_active_cycles", cnt_act, 640);
        check_int("line_hsync_cycles", cnt_hs, 96);
        check_int("line_hsync_start_x", first_hs, 656);
        check_int("line_start_count", cnt_ls, 1);
        tick(1'b1, 1'b0, '0);
        check_int("line_y_after_800", int'(b_y), 1);

        // Full frames on the reduced instance
        do_reset("rst_frame");
        cnt_vs = 0; cnt_bad = 0; cnt_fs = 0; f0 = -1; f1 = -1;
        for (int i = 0; i < 2 * SHT * SVT; i++) begin
            tick(1'b1, 1'b0, '0);
            if (i < SHT * SVT) begin
                if (!s_vs) begin
                    cnt_vs++;
                    if (int'(s_y) != SVA + SVF && int'(s_y) != SVA + SVF + 1) cnt_bad++;
                end
                if (s_act && int'(s_y) >= SVA) cnt_bad++;
            end
            if (s_fs) begin
                cnt_fs++;
                if (f0 < 0) f0 = i; else if (f1 < 0) f1 = i;
            end
        end
        check_int("frame_vsync_cycles", cnt_vs, SVS * SHT);
        check_int("frame_bad_vsync_or_active", cnt_bad, 0);
        check_int("frame_start_count", cnt_fs, 2);
        check_int("frame_period", f1 - f0, SHT * SVT);

        // ce toggling doubles the frame period in clk cycles
        do_reset("rst_toggle");
        prev_fs = 1'b0; f0 = -1; f1 = -1;
        for (int i = 0; i < 4 * SHT * SVT + 4; i++) begin
            tick((i % 2) == 0, 1'b0, '0);
            if (s_fs && !prev_fs) begin
                if (f0 < 0) f0 = i; else if (f1 < 0) f1 = i;
            end
            prev_fs = s_fs;
        end
        check_int("toggle_frame_period", f1 - f0, 2 * SHT * SVT);

        // Mid-frame asynchronous reset at small (10,5)
        do_reset("rst_pre_mid");
        for (int i = 0; i < 1 + 5 * SHT + 10; i++) tick(1'b1, 1'b0, '0);
        check_int("mid_x", int'(s_x), 10);
        check_int("mid_y", int'(s_y), 5);
        do_reset("rst_mid");
        tick(1'b1, 1'b0, '0);
        check("after_mid_big", b_obs, mk(0, 0, 1, 1, 1, 1, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
